// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the SRAM access arbiter: state encoding,
// default bus widths, controller write latency and a saturating-count helper.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_TX    = 2'd2
  } arb_state_e;

  localparam int DEF_DATA_W      = 32;
  localparam int DEF_WR_ADDR_W   = 18;
  localparam int DEF_RD_ADDR_W   = 16;
  localparam int CTRL_WR_LATENCY = 5;
  localparam int STAT_W          = 16;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

endpackage

// File: rtl/sram_access_arbiter_if.sv
// Arbiter <-> SRAM controller bus: read-out mode/address plus the write handshake.
// The arbiter is the master; the controller is the slave.
interface sram_access_arbiter_if
  import sram_arb_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int WR_ADDR_W = DEF_WR_ADDR_W,
  parameter int RD_ADDR_W = DEF_RD_ADDR_W
);
  logic                 tx_mode;
  logic [RD_ADDR_W-1:0] rd_addr;
  logic                 wr_valid;
  logic                 wr_ready;
  logic [WR_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]    wr_data;

  modport master (
    output tx_mode, rd_addr, wr_valid, wr_addr, wr_data,
    input  wr_ready
  );

  modport slave (
    input  tx_mode, rd_addr, wr_valid, wr_addr, wr_data,
    output wr_ready
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. The registered pointer remembers which port
// was served last; it moves only when a grant is actually taken (advance).
module rr_arb2
  import sram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  // 1 means port 1 was served last, so the first contended grant goes to port 0
  logic last_q;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (advance && (|gnt)) begin
      last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares the SRAM controller between two write clients and one streaming TX client.
// Optional statistics counters are built when SRAM_ARB_STATS_EN is defined.
module sram_access_arbiter
  import sram_arb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WR_ADDR_W   = DEF_WR_ADDR_W,
  parameter int RD_ADDR_W   = DEF_RD_ADDR_W,
  parameter int TX_PRIORITY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 w0_valid,
  output logic                 w0_ready,
  input  logic [WR_ADDR_W-1:0] w0_addr,
  input  logic [DATA_W-1:0]    w0_data,
  input  logic                 w1_valid,
  output logic                 w1_ready,
  input  logic [WR_ADDR_W-1:0] w1_addr,
  input  logic [DATA_W-1:0]    w1_data,
  input  logic                 tx_req,
  input  logic [RD_ADDR_W-1:0] tx_base,
  input  logic                 tx_step,
  output logic                 tx_active,
  output logic                 busy,
`ifdef SRAM_ARB_STATS_EN
  input  logic                 stat_clr,
  output logic [STAT_W-1:0]    stat_wr0_cnt,
  output logic [STAT_W-1:0]    stat_wr1_cnt,
  output logic [STAT_W-1:0]    stat_tx_cnt,
`endif
  sram_access_arbiter_if.master ctrl
);

  arb_state_e           state_q;
  logic                 tx_mode_q;
  logic                 wr_valid_q;
  logic [RD_ADDR_W-1:0] rd_addr_q;
  logic [WR_ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0]    wr_data_q;

  logic [1:0] wr_req;
  logic [1:0] gnt;
  logic       any_wr;
  logic       tx_pick;
  logic       wr_pick;

  assign wr_req  = {w1_valid, w0_valid};
  assign any_wr  = |wr_req;
  assign tx_pick = (state_q == ST_IDLE) && tx_req && ((TX_PRIORITY != 0) || !any_wr);
  // Ready is combinational, so keep it low while reset is held
  assign wr_pick = !rst && (state_q == ST_IDLE) && any_wr && !tx_pick;

  rr_arb2 u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (wr_req),
    .advance (wr_pick),
    .gnt     (gnt)
  );

  assign w0_ready  = wr_pick & gnt[0];
  assign w1_ready  = wr_pick & gnt[1];
  assign tx_active = tx_mode_q;
  assign busy      = (state_q != ST_IDLE);

  assign ctrl.tx_mode  = tx_mode_q;
  assign ctrl.rd_addr  = rd_addr_q;
  assign ctrl.wr_valid = wr_valid_q;
  assign ctrl.wr_addr  = wr_addr_q;
  assign ctrl.wr_data  = wr_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tx_mode_q  <= 1'b0;
      wr_valid_q <= 1'b0;
      rd_addr_q  <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (tx_pick) begin
            state_q   <= ST_TX;
            tx_mode_q <= 1'b1;
            rd_addr_q <= tx_base;
          end else if (wr_pick) begin
            state_q    <= ST_WRITE;
            wr_valid_q <= 1'b1;
            wr_addr_q  <= gnt[1] ? w1_addr : w0_addr;
            wr_data_q  <= gnt[1] ? w1_data : w0_data;
          end
        end
        ST_WRITE: begin
          if (ctrl.wr_ready) begin
            state_q    <= ST_IDLE;
            wr_valid_q <= 1'b0;
          end
        end
        ST_TX: begin
          // Leaving TX takes precedence over a same-cycle step
          if (!tx_req) begin
            state_q   <= ST_IDLE;
            tx_mode_q <= 1'b0;
          end else if (tx_step) begin
            rd_addr_q <= rd_addr_q + RD_ADDR_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic [2:0] stat_inc;
  assign stat_inc = {tx_pick && !rst, w1_ready, w0_ready};

  for (genvar gi = 0; gi < 3; gi++) begin : g_stat
    logic [STAT_W-1:0] cnt_q;
    logic [STAT_W-1:0] cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (stat_clr) begin
        cnt_d = '0;
      end else if (stat_inc[gi]) begin
        cnt_d = sat_inc(cnt_q);
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign stat_wr0_cnt = g_stat[0].cnt_q;
  assign stat_wr1_cnt = g_stat[1].cnt_q;
  assign stat_tx_cnt  = g_stat[2].cnt_q;
`endif

endmodule
